// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers: delayed-capture multiplier and
// an iterative radix-2 restoring divider behind a three-state FSM.
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  localparam logic [5:0] MulLast = 6'(MUL_CYCLES);
  localparam logic [5:0] DivLast = 6'd33;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // a_q doubles as the multiplicand and as the divider's dividend/quotient shift register
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        launch_sgn;

  always_comb begin
    if (sgn_q) begin
      prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end
  end

  // The shifted-in remainder never exceeds 2*d-1, so bit 32 of diff is a clean borrow flag.
  assign shifted  = {rem_q, a_q[31]};
  assign diff     = shifted - {1'b0, b_q};
  assign borrow   = diff[32];
  assign quot_fix = neg_quot_q ? (32'd0 - a_q) : a_q;
  assign rem_fix  = neg_rem_q ? (32'd0 - rem_q) : rem_q;
  assign launch_sgn = ~op[0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    sgn_d      = sgn_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = 6'd1;
          sgn_d = launch_sgn;
          if (op[1]) begin
            state_d    = StDiv;
            a_d        = (launch_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
            b_d        = (launch_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;
            neg_quot_d = launch_sgn & (src_a[31] ^ src_b[31]);
            neg_rem_d  = launch_sgn & src_a[31];
            dz_d       = (src_b == 32'd0);
            rem_d      = 32'd0;
          end else begin
            state_d = StMul;
            a_d     = src_a;
            b_d     = src_b;
          end
        end else begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      StMul: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MulLast) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = 6'd0;
          state_d = StIdle;
        end
      end
      StDiv: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DivLast) begin
          if (!dz_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
          cnt_d   = 6'd0;
          state_d = StIdle;
        end else begin
          a_d   = {a_q[30:0], ~borrow};
          rem_d = borrow ? shifted[31:0] : diff[31:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rem_q      <= 32'd0;
      sgn_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      sgn_q      <= sgn_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/latency,
// a monitor pops and compares whenever busy falls.
module tb_muldiv_unit;

  localparam int MulCycles = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.MUL_CYCLES(MulCycles)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks the committed result when busy falls.
  initial begin
    bit   prev = 1'b0;
    int   cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (busy) cnt++;
        if (prev && !busy) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_commit: busy fell with no operation expected");
          end else begin
            e = sb_q.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("latency", 32'(cnt), 32'(e.lat));
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Reference model: plain 64-bit arithmetic from the MIPS definitions.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mt);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] sa;
    logic [63:0] sb;
    longint      x;
    longint      y;
    longint      qq;
    longint      rr;
    logic [31:0] old_hi;
    wait_idle();
    old_hi = m_hi;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p = {m_hi, m_lo};
        end else begin
          x  = (o == 2'b10) ? longint'(sa) : longint'({32'd0, a});
          y  = (o == 2'b10) ? longint'(sb) : longint'({32'd0, b});
          qq = x / y;
          rr = x % y;
          p  = {rr[31:0], qq[31:0]};
        end
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.lat = o[1] ? 33 : MulCycles;
    m_hi = e.hi;
    m_lo = e.lo;
    sb_q.push_back(e);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    hi_we = mt;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    if (mt) check("mthi_with_start", hi, old_hi);
  endtask

  initial begin
    logic [31:0] corners[6];
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'hFFFF_FFFE;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst = 1'b1;

    // MTLO alone
    @(posedge clk);
    #1;
    src_a = 32'h1234_5678;
    lo_we = 1'b1;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    m_lo = 32'h1234_5678;
    check("mtlo_lo", lo, m_lo);
    check("mtlo_hi", hi, m_hi);

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // start and MT writes while busy must be ignored
    issue(2'b11, 32'h0BAD_F00D, 32'd0, 1'b0);
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'h5555_AAAA;
    src_b = 32'h0000_0007;
    hi_we = 1'b1;
    lo_we = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    issue(2'b01, 32'h0000_1234, 32'h0000_5678, 1'b0);
    start = 1'b1;
    op    = 2'b11;
    src_a = 32'h0000_0009;
    src_b = 32'h0000_0002;
    @(posedge clk);
    #1;
    start = 1'b0;

    // MTHI in the same cycle as start: start wins
    issue(2'b00, 32'hCAFE_0001, 32'h0000_0010, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
      issue(2'($urandom_range(0, 3)), ra, rb, 1'b0);
    end

    // Reset mid-DIV: operation aborts without committing
    issue(2'b10, 32'h7654_3210, 32'h0000_0123, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, m_hi);
    check("abort_lo", lo, m_lo);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_hi", hi, 32'd0);
    check("post_abort_lo", lo, 32'd0);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
